// File: rtl/left_shift_seq_block_if.sv
// Operand/result handshake bundle for left_shift_seq_block.
interface left_shift_seq_block_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [1:0]            op_i;
    logic [WORD_WIDTH-1:0] a_i;
    logic [WORD_WIDTH-1:0] b_i;
    logic [WORD_WIDTH-2:0] c_i;
    logic                  cf_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [WORD_WIDTH-1:0] r_o;
    logic                  cf_o;
    logic                  zf_o;
    logic                  of_o;
    logic                  pf_o;
    logic                  sf_o;

    modport master (
        output in_valid_i, op_i, a_i, b_i, c_i, cf_i, out_ready_i,
        input  in_ready_o, out_valid_o, r_o,
        input  cf_o, zf_o, of_o, pf_o, sf_o
    );

    modport slave (
        input  in_valid_i, op_i, a_i, b_i, c_i, cf_i, out_ready_i,
        output in_ready_o, out_valid_o, r_o,
        output cf_o, zf_o, of_o, pf_o, sf_o
    );
endinterface

// File: rtl/left_shift_seq_block.sv
// Multi-cycle left shift/rotate unit (SHL, ROL, RCL, SHLD) with flags.
// Define LEFT_SHIFT_MULTIBIT_EN to retire up to four bits per clock.
module left_shift_seq_block #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    left_shift_seq_block_if.slave bus
);
    localparam int CW  = $clog2(WORD_WIDTH);
    localparam int MSB = WORD_WIDTH - 1;
`ifdef LEFT_SHIFT_MULTIBIT_EN
    localparam int STEPS = 4;
`else
    localparam int STEPS = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic [WORD_WIDTH-1:0] r_res;
    logic                  r_cf;
    logic [WORD_WIDTH-2:0] r_fill;
    logic [CW-1:0]         r_cnt;
    logic                  r_msb;

    logic                  w_accept;
    logic                  w_take;
    logic                  w_last;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic [CW-1:0]         w_n;
    logic [WORD_WIDTH-1:0] w_res;
    logic                  w_cf;
    logic [WORD_WIDTH-2:0] w_fill;
    logic                  w_unused_b;

    assign w_n        = bus.b_i[CW-1:0];
    assign w_unused_b = ^bus.b_i[WORD_WIDTH-1:CW];
    assign w_accept   = bus.in_valid_i & w_in_ready;
    assign w_take     = bus.out_ready_i & w_out_valid;
    assign w_last     = int'(r_cnt) <= STEPS;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    w_next = (w_n != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Chain of single-bit steps; steps beyond the remaining count are skipped.
    always_comb begin
        logic w_fbit;
        w_res  = r_res;
        w_cf   = r_cf;
        w_fill = r_fill;
        w_fbit = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
            if (k < int'(r_cnt)) begin
                w_fbit = w_fill[WORD_WIDTH-2];
                unique case (r_op)
                    2'b00: begin
                        w_cf  = w_res[MSB];
                        w_res = {w_res[MSB-1:0], 1'b0};
                    end
                    2'b01: begin
                        w_res = {w_res[MSB-1:0], w_res[MSB]};
                        w_cf  = w_res[0];
                    end
                    2'b10: begin
                        {w_cf, w_res} = {w_res, w_cf};
                    end
                    default: begin
                        w_cf  = w_res[MSB];
                        w_res = {w_res[MSB-1:0], w_fbit};
                    end
                endcase
                w_fill = {w_fill[WORD_WIDTH-3:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op   <= 2'b00;
            r_res  <= '0;
            r_cf   <= 1'b0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_msb  <= 1'b0;
        end else if (w_accept) begin
            r_op   <= bus.op_i;
            r_res  <= bus.a_i;
            r_cf   <= bus.cf_i;
            r_fill <= bus.c_i;
            r_cnt  <= w_n;
            r_msb  <= bus.a_i[MSB];
        end else if (r_state == SHIFT) begin
            r_res  <= w_res;
            r_cf   <= w_cf;
            r_fill <= w_fill;
            r_cnt  <= w_last ? '0 : r_cnt - CW'(STEPS);
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.r_o         = r_res;
    assign bus.cf_o        = r_cf;
    assign bus.zf_o        = (r_res == '0);
    assign bus.sf_o        = r_res[MSB];
    assign bus.of_o        = r_res[MSB] ^ r_msb;
    assign bus.pf_o        = r_res[0];
endmodule

// File: tb/tb_left_shift_seq_block.sv
// Randomized scoreboard bench for left_shift_seq_block (WORD_WIDTH=8).
// Reference model uses whole-word arithmetic on the shift count.
module tb_left_shift_seq_block;
    localparam int WW = 8;

    typedef struct {
        logic [1:0]    op;
        logic [WW-1:0] a;
        logic [WW-1:0] b;
        logic [WW-2:0] c;
        logic          cf;
        int            hold;
    } txn_t;

    typedef struct {
        int r;
        int cf;
        int amsb;
        int lat;
        int hold;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t q[$];
    exp_t cur;
    bit   active = 1'b0;
    bit   chk_idle = 1'b0;
    int   holdcnt = 0;

    left_shift_seq_block_if #(.WORD_WIDTH(WW)) bus ();

    left_shift_seq_block #(.WORD_WIDTH(WW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   n, a, x, y, mask;
        mask = (1 << WW) - 1;
        n    = int'(t.b) % WW;
        a    = int'(t.a);
        e.r  = a;
        e.cf = int'(t.cf);
        if (n != 0) begin
            case (t.op)
                2'b00: begin
                    e.r  = (a << n) & mask;
                    e.cf = (a >> (WW - n)) & 1;
                end
                2'b01: begin
                    e.r  = ((a << n) | (a >> (WW - n))) & mask;
                    e.cf = e.r & 1;
                end
                2'b10: begin
                    x    = (int'(t.cf) << WW) | a;
                    y    = ((x << n) | (x >> (WW + 1 - n))) & ((1 << (WW + 1)) - 1);
                    e.r  = y & mask;
                    e.cf = y >> WW;
                end
                default: begin
                    x    = (a << (WW - 1)) | int'(t.c);
                    y    = x << n;
                    e.r  = (y >> (WW - 1)) & mask;
                    e.cf = (a >> (WW - n)) & 1;
                end
            endcase
        end
        e.amsb = (a >> (WW - 1)) & 1;
`ifdef LEFT_SHIFT_MULTIBIT_EN
        e.lat = (n + 3) / 4;
`else
        e.lat = n;
`endif
        e.hold = t.hold;
        e.acc  = 0;
        return e;
    endfunction

    task automatic scramble();
        bus.op_i = 2'($urandom);
        bus.a_i  = WW'($urandom);
        bus.b_i  = WW'($urandom);
        bus.c_i  = (WW-1)'($urandom);
        bus.cf_i = 1'($urandom);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 300; k++) begin
            if (bus.in_ready_o) return;
            @(negedge clk);
        end
        chk("in_ready_timeout", int'(bus.in_ready_o), 1);
    endtask

    task automatic drive(input txn_t t);
        bus.op_i       = t.op;
        bus.a_i        = t.a;
        bus.b_i        = t.b;
        bus.c_i        = t.c;
        bus.cf_i       = t.cf;
        bus.in_valid_i = 1'b1;
    endtask

    task automatic issue(input txn_t t);
        exp_t e;
        wait_ready();
        drive(t);
        e     = model(t);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            if (bus.in_ready_o) break;
            bus.in_valid_i = 1'($urandom);
            scramble();
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic reset_mid_shift();
        txn_t t;
        t = '{op: 2'b00, a: WW'($urandom), b: 8'd7, c: '0, cf: 1'b0, hold: 0};
        wait_ready();
        drive(t);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_mid_r", int'(bus.r_o), 0);
        chk("rst_mid_cf", int'(bus.cf_o), 0);
        chk("rst_mid_in_ready", int'(bus.in_ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_idle) begin
                chk("ready_after_take", int'(bus.in_ready_o), 1);
                chk("valid_after_take", int'(bus.out_valid_o), 0);
                chk_idle = 1'b0;
            end
            if (bus.out_valid_o) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        nchk++;
                        nerr++;
                        $display("FAIL unexpected_out_valid: got 1, expected 0 at cycle %0d", cyc);
                    end else begin
                        cur     = q.pop_front();
                        active  = 1'b1;
                        holdcnt = cur.hold;
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end
                if (active) begin
                    chk("r", int'(bus.r_o), cur.r);
                    chk("cf", int'(bus.cf_o), cur.cf);
                    chk("zf", int'(bus.zf_o), int'(cur.r == 0));
                    chk("sf", int'(bus.sf_o), (cur.r >> (WW - 1)) & 1);
                    chk("of", int'(bus.of_o), ((cur.r >> (WW - 1)) & 1) ^ cur.amsb);
                    chk("pf", int'(bus.pf_o), cur.r & 1);
                    chk("in_ready_busy", int'(bus.in_ready_o), 0);
                end
                if (holdcnt > 0) begin
                    bus.out_ready_i = 1'b0;
                    holdcnt--;
                end else begin
                    bus.out_ready_i = ($urandom_range(0, 3) != 0);
                end
                if (bus.out_ready_i && active) begin
                    active   = 1'b0;
                    chk_idle = 1'b1;
                end
            end else begin
                bus.out_ready_i = 1'($urandom);
            end
        end
    end

    initial begin
        txn_t dir[7];
        txn_t t;
        dir[0] = '{op: 2'b00, a: 8'h81, b: 8'd1, c: 7'h00, cf: 1'b0, hold: 0};
        dir[1] = '{op: 2'b00, a: 8'h80, b: 8'd1, c: 7'h00, cf: 1'b0, hold: 0};
        dir[2] = '{op: 2'b00, a: 8'h01, b: 8'd8, c: 7'h00, cf: 1'b1, hold: 0};
        dir[3] = '{op: 2'b01, a: 8'h96, b: 8'd4, c: 7'h00, cf: 1'b0, hold: 5};
        dir[4] = '{op: 2'b10, a: 8'h80, b: 8'd2, c: 7'h00, cf: 1'b0, hold: 0};
        dir[5] = '{op: 2'b11, a: 8'h0F, b: 8'd3, c: 7'b1010000, cf: 1'b0, hold: 0};
        dir[6] = '{op: 2'b00, a: 8'h01, b: 8'd7, c: 7'h00, cf: 1'b0, hold: 0};

        bus.in_valid_i = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        chk("reset_out_valid", int'(bus.out_valid_o), 0);
        chk("reset_in_ready", int'(bus.in_ready_o), 1);
        chk("reset_r", int'(bus.r_o), 0);
        chk("reset_cf", int'(bus.cf_o), 0);
        chk("reset_zf", int'(bus.zf_o), 1);
        chk("reset_of", int'(bus.of_o), 0);
        chk("reset_sf", int'(bus.sf_o), 0);
        chk("reset_pf", int'(bus.pf_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir[i]) issue(dir[i]);
        reset_mid_shift();
        for (int i = 0; i < 200; i++) begin
            t.op   = 2'($urandom);
            t.a    = WW'($urandom);
            t.b    = WW'($urandom);
            t.c    = (WW-1)'($urandom);
            t.cf   = 1'($urandom);
            t.hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
            issue(t);
        end

        for (int k = 0; k < 500; k++) begin
            if (q.size() == 0 && !active) break;
            @(negedge clk);
        end
        chk("drain_pending", q.size() + int'(active), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
